fpu_mul_seq: RTL

FPU_MUL_SEQ -- requirements
Module: fpu_mul_seq

---
 rtl/fpu_mul_seq.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/fpu_mul_seq.sv
// Sequential floating-point multiplier: one shift-add partial product per
// cycle, then a single normalise/round step. The latency is fixed regardless
// of operand class, so special cases also run the full multiply sequence.
module fpu_mul_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [1:0]             rmode,
  input  logic [EXP_W+MAN_W:0]   opa,
  input  logic [EXP_W+MAN_W:0]   opb,
  output logic                   busy,
  output logic                   done,
  output logic [EXP_W+MAN_W:0]   out,
  output logic                   snan,
  output logic                   qnan,
  output logic                   inf,
  output logic                   ine,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   zero
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 1;          // significand width incl. hidden bit
  localparam int PW = 2 * SW;             // full product width
  localparam int ES = EXP_W + 2;          // signed exponent working width
  localparam int CW = $clog2(SW + 1);

  localparam logic [ES-1:0] BIAS    = ES'((2 ** (EXP_W - 1)) - 1);
  localparam logic [ES-1:0] EXP_MAX = ES'((2 ** EXP_W) - 1);
  localparam logic [CW-1:0] LAST    = CW'(SW - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_UNPACK = 3'd1;
  localparam logic [2:0] S_MUL    = 3'd2;
  localparam logic [2:0] S_ROUND  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]    state;
  logic [W-1:0]  a_r, b_r;
  logic [1:0]    rm_r;
  logic          sign_r;
  logic [ES-1:0] exp_r;
  logic          cls_nan, cls_snan, cls_inf, cls_zero;
  logic [PW-1:0] mc;
  logic [SW-1:0] mp;
  logic [PW-1:0] prod;
  logic [CW-1:0] cnt;

  // Field extraction and operand classification of the captured operands.
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_man, b_man;
  logic a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;

  always_comb begin
    a_exp  = a_r[W-2 -: EXP_W];
    b_exp  = b_r[W-2 -: EXP_W];
    a_man  = a_r[MAN_W-1:0];
    b_man  = b_r[MAN_W-1:0];
    a_nan  = (&a_exp) && (a_man != '0);
    b_nan  = (&b_exp) && (b_man != '0);
    a_snan = a_nan && !a_man[MAN_W-1];
    b_snan = b_nan && !b_man[MAN_W-1];
    a_inf  = (&a_exp) && (a_man == '0);
    b_inf  = (&b_exp) && (b_man == '0);
    // Subnormal operands are flushed, so any zero exponent counts as zero.
    a_zero = (a_exp == '0);
    b_zero = (b_exp == '0);
  end

  // Normalise, round and classify the finished product into the result word.
  logic             norm;
  logic [PW-1:0]    pn;
  logic [MAN_W-1:0] man_t;
  logic             g_b, r_b, s_b, lost, up;
  logic [MAN_W:0]   man_sum;
  logic [ES-1:0]    exp_f;
  logic             ovf, unf, ovf_inf;
  logic [W-1:0]     res;
  logic [6:0]       res_flg;             // {snan,qnan,inf,ine,ovf,unf,zero}

  always_comb begin
    norm    = prod[PW-1];
    pn      = norm ? prod : (prod << 1);
    man_t   = pn[PW-2:MAN_W+1];
    g_b     = pn[MAN_W];
    r_b     = pn[MAN_W-1];
    s_b     = |pn[MAN_W-2:0];
    lost    = g_b | r_b | s_b;
    case (rm_r)
      2'd0:    up = g_b & (r_b | s_b | man_t[0]);
      2'd2:    up = lost & !sign_r;
      2'd3:    up = lost & sign_r;
      default: up = 1'b0;
    endcase
    man_sum = {1'b0, man_t} + (MAN_W+1)'(up);
    exp_f   = exp_r + ES'(norm) + ES'(man_sum[MAN_W]);
    ovf     = !exp_f[ES-1] && (exp_f >= EXP_MAX);
    unf     = exp_f[ES-1] || (exp_f == '0);
    ovf_inf = (rm_r == 2'd0) || ((rm_r == 2'd2) && !sign_r) ||
              ((rm_r == 2'd3) && sign_r);
    res     = '0;
    res_flg = '0;
    if (cls_nan) begin
      res     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      res_flg = {cls_snan, 1'b1, 5'b0};
    end else if (cls_inf) begin
      res     = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      res_flg = 7'b0010000;
    end else if (cls_zero) begin
      res     = {sign_r, {(W-1){1'b0}}};
      res_flg = 7'b0000001;
    end else if (ovf) begin
      if (ovf_inf) begin
        res     = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        res_flg = 7'b0011100;
      end else begin
        res     = {sign_r, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
        res_flg = 7'b0001100;
      end
    end else if (unf) begin
      res     = {sign_r, {(W-1){1'b0}}};
      res_flg = 7'b0001011;
    end else begin
      res     = {sign_r, exp_f[EXP_W-1:0], man_sum[MAN_W-1:0]};
      res_flg = {3'b000, lost, 3'b000};
    end
  end

  // Control FSM plus operand capture, shift-add multiply and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      a_r       <= '0;
      b_r       <= '0;
      rm_r      <= '0;
      sign_r    <= 1'b0;
      exp_r     <= '0;
      cls_nan   <= 1'b0;
      cls_snan  <= 1'b0;
      cls_inf   <= 1'b0;
      cls_zero  <= 1'b0;
      mc        <= '0;
      mp        <= '0;
      prod      <= '0;
      cnt       <= '0;
      out       <= '0;
      snan      <= 1'b0;
      qnan      <= 1'b0;
      inf       <= 1'b0;
      ine       <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      zero      <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            a_r   <= opa;
            b_r   <= opb;
            rm_r  <= rmode;
            state <= S_UNPACK;
          end else begin
            state <= S_IDLE;
          end
        end
        S_UNPACK: begin
          sign_r   <= a_r[W-1] ^ b_r[W-1];
          exp_r    <= ES'(a_exp) + ES'(b_exp) - BIAS;
          cls_nan  <= a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
          cls_snan <= a_snan | b_snan;
          cls_inf  <= a_inf | b_inf;
          cls_zero <= a_zero | b_zero;
          mc       <= PW'({1'b1, a_man});
          mp       <= {1'b1, b_man};
          prod     <= '0;
          cnt      <= '0;
          state    <= S_MUL;
        end
        S_MUL: begin
          prod <= prod + (mp[0] ? mc : '0);
          mc   <= mc << 1;
          mp   <= mp >> 1;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) state <= S_ROUND;
        end
        S_ROUND: begin
          out       <= res;
          snan      <= res_flg[6];
          qnan      <= res_flg[5];
          inf       <= res_flg[4];
          ine       <= res_flg[3];
          overflow  <= res_flg[2];
          underflow <= res_flg[1];
          zero      <= res_flg[0];
          state     <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // DONE is not busy so a new request can be taken in the done cycle.
  always_comb begin
    busy = (state == S_UNPACK) || (state == S_MUL) || (state == S_ROUND);
    done = (state == S_DONE);
  end

endmodule
